// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the rv32 pipeline.
//   exception_cause_e    - trap cause encodings
//   if_id_pipeline_reg_t - IF/ID pipeline register {instr, pc, valid}
//   fetch_state_e        - fetch-stage control states
//   fetch_entry_t        - one prefetch FIFO entry {instr, pc}
//   INSTR_NOP            - canonical NOP (addi x0, x0, 0)
package rv32_pkg;

   typedef enum logic [3:0] {
      EXC_INSTR_MISALIGNED   = 4'd0,
      EXC_INSTR_ACCESS_FAULT = 4'd1,
      EXC_ILLEGAL_INSTR      = 4'd2,
      EXC_BREAKPOINT         = 4'd3,
      EXC_LOAD_MISALIGNED    = 4'd4,
      EXC_LOAD_ACCESS_FAULT  = 4'd5,
      EXC_STORE_MISALIGNED   = 4'd6,
      EXC_STORE_ACCESS_FAULT = 4'd7,
      EXC_ECALL_U            = 4'd8,
      EXC_ECALL_M            = 4'd11
   } exception_cause_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } if_id_pipeline_reg_t;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_RUN,
      FS_HALT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo: prefetch buffer of {instr, pc} entries for the IF stage.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write one entry (caller guarantees space or concurrent pop)
//   pop         - drop the head entry (ignored when empty)
//   flush       - discard all entries, overrides push/pop
//   head        - oldest entry, valid when !empty
//   empty, full - occupancy flags
//   count       - number of stored entries
module rv32_fetch_fifo
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fetch_entry_t  din,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   rd_ptr_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign head    = mem[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/rv32_if_stage.sv
// rv32_if_stage: instruction-fetch stage. Owns the PC, issues word fetches
// over a valid/ready request channel, buffers in-order responses in a
// prefetch FIFO and drives the IF/ID register consumed by decode.
//   RESET_PC, FIFO_DEPTH           - first fetch address, prefetch entries
//   clk, rst_n                     - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      - fetch request channel
//   imem_rsp_valid/data            - in-order, never back-pressured responses
//   redirect_valid/redirect_pc     - load new PC and flush the stage
//   stall                          - hold the IF/ID register
//   if_id                          - {instr, pc, valid} to decode
//   if_exc_valid/cause/tval        - fetch exception alongside if_id
// Build option: RV32_IF_MISALIGN_CHECK_EN defined -> a misaligned redirect
// raises EXC_INSTR_MISALIGNED and halts fetch until the next redirect;
// undefined -> redirect_pc[1:0] is forced to zero and the exception
// outputs stay at their reset values.
module rv32_if_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [31:0]         imem_req_addr,
   input  logic                imem_rsp_valid,
   input  logic [31:0]         imem_rsp_data,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   input  logic                stall,
   output if_id_pipeline_reg_t if_id,
   output logic                if_exc_valid,
   output exception_cause_e    if_exc_cause,
   output logic [31:0]         if_exc_tval
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

   fetch_state_e        state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]       outstanding_q, outstanding_d;
   logic [CW-1:0]       drop_q, drop_d;
   if_id_pipeline_reg_t if_id_q, if_id_d;

   logic                req_fire;
   logic                rsp_drop;
   logic                rsp_keep;
   logic                bypass;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_empty;
   logic                fifo_full;
   logic [CW-1:0]       fifo_count;
   fetch_entry_t        fifo_head;
   logic [CW:0]         credit_used;
   logic [31:0]         redirect_target;
   logic                misalign_redirect;

`ifdef RV32_IF_MISALIGN_CHECK_EN
   assign redirect_target   = redirect_pc;
   assign misalign_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_target   = redirect_pc & 32'hFFFF_FFFC;
   assign misalign_redirect = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FS_BOOT;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FS_BOOT: state_d = FS_RUN;
         FS_RUN:  state_d = FS_RUN;
         FS_HALT: state_d = FS_HALT;
         default: state_d = FS_BOOT;
      endcase
      if (redirect_valid) state_d = misalign_redirect ? FS_HALT : FS_RUN;
   end

   // ---------------- FSM: outputs ----------------
   // Credit covers both in-flight and buffered words, so every response is
   // guaranteed a FIFO slot even while decode is stalled. The IF/ID register
   // is a separate slot and never consumes credit. Registered state only.
   always_comb begin
      credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
      imem_req_valid = (state_q == FS_RUN) && (credit_used < CREDIT_MAX);
      imem_req_addr  = pc_q;
   end

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign rsp_drop  = imem_rsp_valid && (redirect_valid || (drop_q != '0));
   assign rsp_keep  = imem_rsp_valid && !rsp_drop;
   assign bypass    = rsp_keep && fifo_empty && !stall;
   assign fifo_push = rsp_keep && !bypass;
   assign fifo_pop  = !redirect_valid && !stall && !fifo_empty;

   rv32_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   ({imem_rsp_data, rsp_pc_q}),
      .pop   (fifo_pop),
      .flush (redirect_valid),
      .head  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Datapath next-state. rsp_pc tracks the address of the next response
   // that will be kept; stale responses never advance it.
   always_comb begin
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_d        = drop_q;
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      if_id_d       = if_id_q;

      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         drop_d   = outstanding_d;
         pc_d     = redirect_target;
         rsp_pc_d = redirect_target;
         if (misalign_redirect) begin
            if_id_d = '{instr: INSTR_NOP, pc: redirect_pc, valid: 1'b1};
         end else begin
            if_id_d = '{instr: INSTR_NOP, pc: if_id_q.pc, valid: 1'b0};
         end
      end else begin
         if (rsp_drop) drop_d = drop_q - CW'(1);
         if (req_fire) pc_d = pc_q + 32'd4;
         if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
         if (!stall) begin
            if (!fifo_empty) begin
               if_id_d = '{instr: fifo_head.instr, pc: fifo_head.pc, valid: 1'b1};
            end else if (bypass) begin
               if_id_d = '{instr: imem_rsp_data, pc: rsp_pc_q, valid: 1'b1};
            end else begin
               if_id_d = '{instr: INSTR_NOP, pc: if_id_q.pc, valid: 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         if_id_q       <= '{instr: INSTR_NOP, pc: RESET_PC, valid: 1'b0};
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         if_id_q       <= if_id_d;
      end
   end

   assign if_id        = if_id_q;
   assign if_exc_cause = EXC_INSTR_MISALIGNED;

`ifdef RV32_IF_MISALIGN_CHECK_EN
   logic        exc_valid_q;
   logic [31:0] exc_tval_q;

   // The exception travels with the IF/ID entry: held while stalled,
   // cleared as soon as decode takes the next entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_valid_q <= 1'b0;
         exc_tval_q  <= '0;
      end else if (redirect_valid) begin
         exc_valid_q <= misalign_redirect;
         if (misalign_redirect) exc_tval_q <= redirect_pc;
      end else if (!stall) begin
         exc_valid_q <= 1'b0;
      end
   end

   assign if_exc_valid = exc_valid_q;
   assign if_exc_tval  = exc_tval_q;
`else
   assign if_exc_valid = 1'b0;
   assign if_exc_tval  = '0;
`endif

   a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (outstanding_q != '0));
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_push |-> (!fifo_full || fifo_pop));

endmodule
